// File: rtl/motor_rpm_plant_if.sv
// Command/feedback bundle between drone_top and the four-motor RPM plant model.
// master drives the commands and load values; slave returns modelled RPM and status.
interface motor_rpm_plant_if;
    logic               set;
    logic signed [15:0] rpm_sense_set [3:0];
    logic signed [15:0] mot_set       [3:0];
    logic signed [15:0] rpm_sense     [3:0];
    logic        [3:0]  settled;
    logic               update_tick;

    modport master (
        output set, rpm_sense_set, mot_set,
        input  rpm_sense, settled, update_tick
    );

    modport slave (
        input  set, rpm_sense_set, mot_set,
        output rpm_sense, settled, update_tick
    );
endinterface

// File: rtl/motor_rpm_plant.sv
// Four-motor RPM plant: each motor slews toward its clamped setpoint once per update tick,
// with per-motor settle detection and a force-load path that breaks the control loop.
module motor_rpm_plant #(
    parameter int unsigned SLEW         = 64,
    parameter int unsigned UPDATE_DIV   = 4,
    parameter int          RPM_MIN      = 0,
    parameter int          RPM_MAX      = 16000,
    parameter int unsigned SETTLE_TICKS = 3
) (
    input  logic               clk,
    input  logic               resetn,
    motor_rpm_plant_if.slave   bus
);

    localparam int unsigned NUM_MOT = 4;
    localparam int unsigned DIV_W   = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int unsigned STB_W   = 4;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
    localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(SETTLE_TICKS);
    localparam logic signed [15:0] MIN_S    = 16'(RPM_MIN);
    localparam logic signed [15:0] MAX_S    = 16'(RPM_MAX);
    localparam logic signed [15:0] SLEW_S   = 16'(SLEW);
    localparam logic signed [16:0] SLEW_P   = 17'(SLEW);
    localparam logic signed [16:0] SLEW_N   = -17'(SLEW);

    logic [DIV_W-1:0]   div_cnt,    div_nxt;
    logic               tick_q,     tick_nxt;
    logic signed [15:0] rpm_q      [NUM_MOT-1:0];
    logic signed [15:0] rpm_nxt    [NUM_MOT-1:0];
    logic [STB_W-1:0]   stable_q   [NUM_MOT-1:0];
    logic [STB_W-1:0]   stable_nxt [NUM_MOT-1:0];
    logic [3:0]         settled_q,  settled_nxt;
    logic signed [15:0] tgt        [NUM_MOT-1:0];
    logic signed [16:0] diff       [NUM_MOT-1:0];
    logic               upd_edge_c;

    function automatic logic signed [15:0] clamp(input logic signed [15:0] x);
        if (x < MIN_S)      return MIN_S;
        else if (x > MAX_S) return MAX_S;
        else                return x;
    endfunction

    assign upd_edge_c = (div_cnt == DIV_LAST) && !bus.set;

    // Next-state: load has priority, otherwise slew and settle-track on update edges.
    always_comb begin
        div_nxt     = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        tick_nxt    = 1'b0;
        settled_nxt = settled_q;
        for (int i = 0; i < NUM_MOT; i++) begin
            rpm_nxt[i]    = rpm_q[i];
            stable_nxt[i] = stable_q[i];
            tgt[i]        = clamp(bus.mot_set[i]);
            diff[i]       = $signed({tgt[i][15], tgt[i]}) - $signed({rpm_q[i][15], rpm_q[i]});
        end

        if (bus.set) begin
            div_nxt     = '0;
            settled_nxt = '0;
            for (int i = 0; i < NUM_MOT; i++) begin
                rpm_nxt[i]    = clamp(bus.rpm_sense_set[i]);
                stable_nxt[i] = '0;
            end
        end else if (upd_edge_c) begin
            tick_nxt = 1'b1;
            for (int i = 0; i < NUM_MOT; i++) begin
                if (diff[i] > SLEW_P)      rpm_nxt[i] = rpm_q[i] + SLEW_S;
                else if (diff[i] < SLEW_N) rpm_nxt[i] = rpm_q[i] - SLEW_S;
                else                       rpm_nxt[i] = tgt[i];

                if (rpm_nxt[i] != tgt[i])        stable_nxt[i] = '0;
                else if (stable_q[i] < STB_MAX)  stable_nxt[i] = stable_q[i] + STB_W'(1);
                else                             stable_nxt[i] = STB_MAX;

                settled_nxt[i] = (stable_nxt[i] >= STB_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt   <= '0;
            tick_q    <= 1'b0;
            settled_q <= '0;
            for (int i = 0; i < NUM_MOT; i++) begin
                rpm_q[i]    <= '0;
                stable_q[i] <= '0;
            end
        end else begin
            div_cnt   <= div_nxt;
            tick_q    <= tick_nxt;
            settled_q <= settled_nxt;
            for (int i = 0; i < NUM_MOT; i++) begin
                rpm_q[i]    <= rpm_nxt[i];
                stable_q[i] <= stable_nxt[i];
            end
        end
    end

    assign bus.rpm_sense   = rpm_q;
    assign bus.settled     = settled_q;
    assign bus.update_tick = tick_q;

endmodule
